lelbc_test_decrypt: RTL and testbench
=====================================

Name: lelbc_test_decrypt

Overview:
Iterative LELBC block decryptor; inverse of the 16-round iterative encryptor. Takes a 64-bit ciphertext and the 128-bit master key, runs a forward key expansion to reach the last round key, then applies 16 inverse rounds while unwinding the key schedule. Uses a valid/ready handshake on both sides so a host or test harness can stream blocks. Sits beside the encryptor and closes the round-trip decrypt(encrypt(P,K),K)=P.

Parameters:
ROUNDS, 16, number of cipher rounds; must match the encryptor.
CW, 5, round-counter width; must satisfy 2^CW > ROUNDS.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  ciphertext/key offered
in_ready  output  1  block can accept a new job
key_reuse  input  1  sampled with in_valid; skip key expansion and use cached last-round key
in  input  [0:63]  ciphertext
key  input  [0:127]  master key K0
out_valid  output  1  plaintext valid
out_ready  input  1  consumer accepts plaintext
result  output  [0:63]  recovered plaintext
busy  output  1  high in KEYEXP or ROUND

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; in_ready=1, out_valid=0, busy=0, result=0, round counter=0, cache_valid=0. Reset wins over every other event, including mid-KEYEXP, mid-ROUND and DONE with out_ready low. Any in-flight job is discarded.
- Notation: K0=key; K(i+1)=KS(Ki,i); encryption round i: S(i+1)=R(Si,Ki,i), i=0..ROUNDS-1; ciphertext=S(ROUNDS).
- Submodules, all combinational: KS (forward key update, same as used by encryptor round), KS_inv with KS_inv(KS(K,i),i)=K, R_inv with R_inv(R(S,K,i),K,i)=S.
- Registers: st[0:63], k[0:127], cnt[CW], kcache[0:127], cache_valid.
- IDLE: in_ready=1. On in_valid&in_ready: st<=in.
  - If key_reuse&cache_valid: k<=kcache, cnt<=ROUNDS-1, go ROUND.
  - Otherwise: k<=key, cnt<=0, go KEYEXP. key_reuse with cache_valid=0 is treated as a normal expansion.
- KEYEXP: each cycle k<=KS(k,cnt), cnt<=cnt+1.
  - On the cycle cnt==ROUNDS-2: kcache<=KS(k,cnt), cache_valid<=1, cnt<=ROUNDS-1, go ROUND.
  - Takes ROUNDS-1 = 15 cycles. k = K15 on entry to ROUND.
- ROUND: each cycle st<=R_inv(st,k,cnt).
  - If cnt!=0: k<=KS_inv(k,cnt-1), cnt<=cnt-1.
  - If cnt==0: result<=R_inv(st,k,0), go DONE.
  - Takes ROUNDS cycles. Indices are processed 15 down to 0. No underflow: cnt is never decremented below 0.
- DONE: out_valid=1; result is held stable while out_valid=1. On out_ready: out_valid<=0, go IDLE. in_ready=0 in DONE (no overlap).
- busy=1 exactly in KEYEXP and ROUND. in_ready=1 only in IDLE.
- Latency, accept edge to out_valid high:
  - Full expansion: 1+15+16 = 32 cycles.
  - key_reuse hit: 1+16 = 17 cycles.
- in, key, key_reuse are ignored outside the IDLE accept cycle; changing them mid-job has no effect.
- cache_valid is cleared only by rst. kcache is overwritten by every full expansion.
- If ROUNDS=1, KEYEXP is skipped: k=K0 and the block goes directly to ROUND with cnt=0.

Test Plan:
- Round-trip: P=64'h0123456789ABCDEF, K=128'h000102030405060708090A0B0C0D0E0F; feed the encryptor's 16-round output as `in` -> out_valid exactly 32 cycles after the accept edge, result=64'h0123456789ABCDEF, busy high for cycles 1..31.
- Key reuse: after the above, send a second ciphertext (encryption of P=64'hFFFFFFFFFFFFFFFF under the same K) with key_reuse=1 -> result=64'hFFFFFFFFFFFFFFFF after 17 cycles, KEYEXP never entered.
- key_reuse=1 right after reset -> full 32-cycle expansion, correct plaintext; next job with key_reuse=1 -> 17 cycles.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1, result stable, in_ready=0, an offered in_valid is not accepted; out_ready=1 -> IDLE next cycle, in_ready=1.
- Reset mid-op: assert rst at cycle 8 (KEYEXP) and separately at cycle 25 (ROUND) -> next cycle out_valid=0, result=0, in_ready=1, cache_valid=0. A following job with key_reuse=1 takes 32 cycles and decrypts correctly.
- Input perturbation: toggle `in` and `key` randomly during KEYEXP/ROUND -> result still equals the plaintext of the values sampled at the accept edge.

Source files
------------

// File: rtl/lelbc_test_decrypt.sv
// Iterative LELBC block decryptor: forward key expansion to the last round key, then
// ROUNDS inverse Feistel rounds while unwinding the key schedule. Caches the last round key.
module lelbc_test_decrypt #(
    parameter int unsigned ROUNDS = 16,
    parameter int unsigned CW     = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          key_reuse,
    input  logic [0:63]   in,
    input  logic [0:127]  key,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [0:63]   result,
    output logic          busy
);

    localparam logic [CW-1:0] LastIdx = CW'(ROUNDS - 1);
    localparam logic [CW-1:0] ExpLast = (ROUNDS > 1) ? CW'(ROUNDS - 2) : '0;
    localparam bit            SkipExp = (ROUNDS == 1);

    typedef enum logic [1:0] {StIdle, StKeyExp, StRound, StDone} state_e;

    // Forward key update: rotate left by 13, fold in the round index.
    function automatic logic [127:0] ks_fwd(input logic [127:0] k, input logic [CW-1:0] i);
        return {k[114:0], k[127:115]} ^ {{(128-CW){1'b0}}, i};
    endfunction

    function automatic logic [127:0] ks_inv(input logic [127:0] k, input logic [CW-1:0] i);
        logic [127:0] t;
        t = k ^ {{(128-CW){1'b0}}, i};
        return {t[12:0], t[127:13]};
    endfunction

    function automatic logic [31:0] round_f(input logic [31:0] x, input logic [127:0] k,
                                            input logic [CW-1:0] i);
        logic [31:0] sum;
        sum = x + k[127:96];
        return {sum[28:0], sum[31:29]} ^ (k[95:64] & ~x) ^ {{(32-CW){1'b0}}, i};
    endfunction

    // Encrypt round maps {l, r} to {r, l ^ F(r)}; this undoes it.
    function automatic logic [63:0] r_inv(input logic [63:0] s, input logic [127:0] k,
                                          input logic [CW-1:0] i);
        return {s[31:0] ^ round_f(s[63:32], k, i), s[63:32]};
    endfunction

    state_e         state_q, state_d;
    logic [63:0]    st_q, st_d;
    logic [127:0]   k_q, k_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [127:0]   kcache_q, kcache_d;
    logic           cache_valid_q, cache_valid_d;
    logic [63:0]    result_q, result_d;

    logic [63:0]    st_rinv;
    logic [127:0]   k_fwd;
    logic [127:0]   k_back;

    assign st_rinv = r_inv(st_q, k_q, cnt_q);
    assign k_fwd   = ks_fwd(k_q, cnt_q);
    assign k_back  = ks_inv(k_q, cnt_q - CW'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            st_q          <= '0;
            k_q           <= '0;
            cnt_q         <= '0;
            kcache_q      <= '0;
            cache_valid_q <= 1'b0;
            result_q      <= '0;
        end else begin
            state_q       <= state_d;
            st_q          <= st_d;
            k_q           <= k_d;
            cnt_q         <= cnt_d;
            kcache_q      <= kcache_d;
            cache_valid_q <= cache_valid_d;
            result_q      <= result_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        st_d          = st_q;
        k_d           = k_q;
        cnt_d         = cnt_q;
        kcache_d      = kcache_q;
        cache_valid_d = cache_valid_q;
        result_d      = result_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    st_d = in;
                    if (key_reuse && cache_valid_q) begin
                        k_d     = kcache_q;
                        cnt_d   = LastIdx;
                        state_d = StRound;
                    end else if (SkipExp) begin
                        // Single-round cipher: K0 is already the last round key.
                        k_d           = key;
                        kcache_d      = key;
                        cache_valid_d = 1'b1;
                        cnt_d         = '0;
                        state_d       = StRound;
                    end else begin
                        k_d     = key;
                        cnt_d   = '0;
                        state_d = StKeyExp;
                    end
                end
            end
            StKeyExp: begin
                k_d   = k_fwd;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == ExpLast) begin
                    kcache_d      = k_fwd;
                    cache_valid_d = 1'b1;
                    cnt_d         = LastIdx;
                    state_d       = StRound;
                end
            end
            StRound: begin
                st_d = st_rinv;
                if (cnt_q != '0) begin
                    k_d   = k_back;
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    result_d = st_rinv;
                    state_d  = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q == StKeyExp) || (state_q == StRound);
    assign result    = result_q;

endmodule

// File: tb/tb_lelbc_test_decrypt.sv
// Scoreboarded bench: plaintexts are encrypted by a reference model, the DUT must recover them
// with the expected latency; a monitor checks every handshake against the expected queue.
module tb_lelbc_test_decrypt;

    localparam int ROUNDS = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          key_reuse;
    logic [0:63]   din;
    logic [0:127]  dkey;
    logic          out_valid;
    logic          out_ready;
    logic [0:63]   result;
    logic          busy;

    always #5 clk = ~clk;

    lelbc_test_decrypt #(.ROUNDS(16), .CW(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .key_reuse (key_reuse),
        .in        (din),
        .key       (dkey),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    typedef struct {
        logic [63:0] pt;
        int          lat;
        int          acc;
    } exp_t;

    exp_t         sbq[$];
    int           vectors = 0;
    int           miscompares = 0;
    int           cyc = 0;
    logic [127:0] cached_key;
    bit           cache_ok = 0;

    // Reference cipher, forward direction only.
    function automatic logic [127:0] m_ks(logic [127:0] k, int i);
        return ((k << 13) | (k >> 115)) ^ 128'(i);
    endfunction

    function automatic logic [31:0] m_f(logic [31:0] x, logic [127:0] k, int i);
        logic [31:0] s;
        s = x + k[127:96];
        return ((s << 3) | (s >> 29)) ^ (k[95:64] & ~x) ^ 32'(i);
    endfunction

    function automatic logic [63:0] encrypt(logic [63:0] p, logic [127:0] k);
        logic [63:0]  s;
        logic [127:0] kk;
        s  = p;
        kk = k;
        for (int i = 0; i < ROUNDS; i++) begin
            s  = {s[31:0], s[63:32] ^ m_f(s[31:0], kk, i)};
            kk = m_ks(kk, i);
        end
        return s;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: compares each presented plaintext against the head of the scoreboard.
    initial begin : monitor
        bit          seen;
        int          busy_cnt;
        logic [63:0] held;
        seen     = 0;
        busy_cnt = 0;
        held     = '0;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                sbq.delete();
                seen     = 0;
                busy_cnt = 0;
            end else begin
                if (busy === 1'b1) busy_cnt++;
                if (out_valid === 1'b1) begin
                    if (!seen) begin
                        seen = 1;
                        held = result;
                        if (sbq.size() == 0) begin
                            vectors++;
                            miscompares++;
                            $display("FAIL unexpected_output result=%h required=none", result);
                        end else begin
                            check("plaintext", result, sbq[0].pt);
                            check("latency", 64'(cyc - sbq[0].acc + 1), 64'(sbq[0].lat));
                            check("busy_cycles", 64'(busy_cnt), 64'(sbq[0].lat - 1));
                        end
                    end else begin
                        check("result_stable", result, held);
                    end
                    check("done_flags", {62'b0, in_ready, busy}, 64'd0);
                    if (out_ready === 1'b1) begin
                        if (sbq.size() > 0) void'(sbq.pop_front());
                        seen     = 0;
                        busy_cnt = 0;
                    end
                end
            end
        end
    end

    // All driver tasks are entered and left 1 time unit after a rising edge.
    task automatic send(input logic [63:0] pt, input logic [127:0] k, input bit reuse);
        logic [127:0] keff;
        int           lat;
        int           n;
        bit           hit;
        hit  = reuse && cache_ok;
        keff = hit ? cached_key : k;
        lat  = hit ? 17 : 32;
        if (!hit) begin
            cached_key = k;
            cache_ok   = 1;
        end
        n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout in_ready=%b required=1", in_ready);
        end
        in_valid  = 1'b1;
        din       = encrypt(pt, keff);
        dkey      = k;
        key_reuse = reuse;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        sbq.push_back('{pt, lat, cyc});
    endtask

    task automatic finish_job(input bit rnd_ready);
        int n;
        n = 0;
        while (sbq.size() > 0 && n < 300) begin
            @(posedge clk);
            #1;
            din       = {$urandom, $urandom};
            dkey      = {$urandom, $urandom, $urandom, $urandom};
            key_reuse = 1'($urandom);
            out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            n++;
        end
        if (n >= 300) begin
            vectors++;
            miscompares++;
            $display("FAIL done_timeout pending=%0d required=0", sbq.size());
        end
        out_ready = 1'b1;
    endtask

    task automatic check_idle(input string name);
        check({name, "_in_ready"}, 64'(in_ready), 64'd1);
        check({name, "_out_valid"}, 64'(out_valid), 64'd0);
        check({name, "_busy"}, 64'(busy), 64'd0);
        check({name, "_result"}, result, 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        cache_ok = 0;
    endtask

    localparam logic [127:0] K_TP = 128'h000102030405060708090A0B0C0D0E0F;

    initial begin
        logic [127:0] k_last;
        int           n;
        rst       = 1'b1;
        in_valid  = 1'b0;
        key_reuse = 1'b0;
        din       = '0;
        dkey      = '0;
        out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_idle("reset");

        send(64'h0123456789ABCDEF, K_TP, 1'b0);
        finish_job(1'b0);
        send(64'hFFFFFFFFFFFFFFFF, 128'h0, 1'b1);
        finish_job(1'b0);

        do_reset();
        check_idle("reset2");
        send(64'h1122334455667788, K_TP, 1'b1);
        finish_job(1'b0);
        send(64'h8877665544332211, 128'h0, 1'b1);
        finish_job(1'b0);

        // Backpressure in DONE with a competing in_valid offered.
        out_ready = 1'b0;
        send(64'hCAFEF00DDEADBEEF, 128'h0, 1'b1);
        n = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("bp_reached_done", 64'(out_valid), 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            din      = {$urandom, $urandom};
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_in_ready", 64'(in_ready), 64'd1);
        check("bp_release_out_valid", 64'(out_valid), 64'd0);
        check("bp_popped", 64'(sbq.size()), 64'd0);

        // Reset during KEYEXP, then during ROUND.
        send(64'h0F0E0D0C0B0A0908, 128'hA5A5_5A5A_1234_5678_9ABC_DEF0_0BAD_F00D, 1'b0);
        repeat (7) @(posedge clk);
        #1;
        do_reset();
        check_idle("rst_keyexp");
        send(64'h0123456789ABCDEF, K_TP, 1'b1);
        finish_job(1'b0);

        send(64'h5555AAAA5555AAAA, 128'h1, 1'b0);
        repeat (24) @(posedge clk);
        #1;
        do_reset();
        check_idle("rst_round");
        send(64'h0123456789ABCDEF, K_TP, 1'b1);
        finish_job(1'b0);

        // Random jobs with perturbed inputs and random backpressure.
        k_last = K_TP;
        for (int j = 0; j < 24; j++) begin
            logic [63:0]  p;
            logic [127:0] k;
            p = {$urandom, $urandom};
            k = ($urandom_range(0, 2) == 0) ? {$urandom, $urandom, $urandom, $urandom} : k_last;
            k_last = k;
            send(p, k, 1'($urandom));
            finish_job(1'b1);
        end

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog_timeout cycles=%0d required=<40000", cyc);
        $fatal(1, "watchdog");
    end

endmodule
